// File: rtl/rs_dec_pkg.sv
// Shared types and constants for the RS(32,28) decoder front end.
package rs_dec_pkg;

  localparam int RS_N  = 32;
  localparam int RS_K  = 28;
  localparam int SYM_W = 8;
  localparam int GAP_W = 4;
  localparam int ERR_W = 16;

  typedef logic [SYM_W-1:0] rs_sym_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_DRAIN,
    ST_EVAL
  } rs_state_e;

  function automatic logic syn_all_zero(input rs_sym_t s0, input rs_sym_t s1,
                                        input rs_sym_t s2, input rs_sym_t s3);
    return ~|{s0, s1, s2, s3};
  endfunction

endpackage

// File: rtl/rs_dec_gap_timer.sv
// Loadable down-counter that saturates at zero; paces symbol strobes.
module rs_dec_gap_timer #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_resb,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero,
  output logic         o_zero_nxt
);

  logic [W-1:0] cnt, cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (i_clr)
      cnt_nxt = '0;
    else if (i_load)
      cnt_nxt = i_load_val;
    else if (cnt != '0)
      cnt_nxt = cnt - W'(1);
  end

  always_ff @(posedge i_clk or negedge i_resb) begin
    if (!i_resb)
      cnt <= '0;
    else
      cnt <= cnt_nxt;
  end

  // The look-ahead flag lets the parent register its ready output.
  assign o_zero     = (cnt == '0);
  assign o_zero_nxt = (cnt_nxt == '0);

endmodule

// File: rtl/rs_dec_frame_ctrl.sv
// Frame sequencer for the RS(32,28) syndrome stage: paces symbols into the
// syndrome calculator, clears it per frame and latches S0..S3 at frame end.
// Define RS_DEC_FRAME_CTRL_STATS_EN to build the erroneous-frame counter.
module rs_dec_frame_ctrl
  import rs_dec_pkg::*;
#(
  parameter int SYM_GAP   = 4,
  parameter int FRAME_LEN = RS_N
) (
  input  logic             i_clk,
  input  logic             i_resb,
  input  logic             i_frame_sync,
  input  logic [7:0]       i_sym,
  input  logic             i_sym_valid,
  output logic             o_sym_ready,
  output logic [7:0]       o_sc_data,
  output logic             o_sc_sync,
  output logic             o_sc_resb,
  input  logic [7:0]       i_s0,
  input  logic [7:0]       i_s1,
  input  logic [7:0]       i_s2,
  input  logic [7:0]       i_s3,
  output logic [7:0]       o_syn0,
  output logic [7:0]       o_syn1,
  output logic [7:0]       o_syn2,
  output logic [7:0]       o_syn3,
  output logic             o_frame_done,
  output logic             o_frame_ok,
  output logic [ERR_W-1:0] o_err_frames
);

  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(SYM_GAP - 1);
  localparam logic [4:0]       LAST_IDX   = 5'(FRAME_LEN - 1);

  rs_state_e  state, state_nxt;
  logic [4:0] sym_cnt;
  logic       xfer;
  logic       gap_zero, gap_zero_nxt;
  logic       syn_ok;

  // An abort on the same cycle as a handshake drops the symbol.
  assign xfer   = (state == ST_LOAD) && i_sym_valid && o_sym_ready && !i_frame_sync;
  assign syn_ok = syn_all_zero(i_s0, i_s1, i_s2, i_s3);

  rs_dec_gap_timer #(
    .W (GAP_W)
  ) u_gap (
    .i_clk      (i_clk),
    .i_resb     (i_resb),
    .i_clr      (state == ST_CLEAR),
    .i_load     (xfer),
    .i_load_val (GAP_RELOAD),
    .o_zero     (gap_zero),
    .o_zero_nxt (gap_zero_nxt)
  );

  always_ff @(posedge i_clk or negedge i_resb) begin
    if (!i_resb)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (i_frame_sync) state_nxt = ST_CLEAR;
      ST_CLEAR: state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (i_frame_sync)
          state_nxt = ST_CLEAR;
        else if (xfer && (sym_cnt == LAST_IDX))
          state_nxt = ST_DRAIN;
      end
      // Gap expiry means the last toggle has crossed the calculator's synchronizer.
      ST_DRAIN: begin
        if (i_frame_sync)
          state_nxt = ST_CLEAR;
        else if (gap_zero)
          state_nxt = ST_EVAL;
      end
      ST_EVAL:  state_nxt = i_frame_sync ? ST_CLEAR : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resb) begin
    if (!i_resb)
      sym_cnt <= '0;
    else if (state == ST_CLEAR)
      sym_cnt <= '0;
    else if (xfer && (sym_cnt != LAST_IDX))
      sym_cnt <= sym_cnt + 5'd1;
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge i_clk or negedge i_resb) begin
    if (!i_resb) begin
      o_sym_ready  <= 1'b0;
      o_sc_data    <= '0;
      o_sc_sync    <= 1'b0;
      o_sc_resb    <= 1'b1;
      o_syn0       <= '0;
      o_syn1       <= '0;
      o_syn2       <= '0;
      o_syn3       <= '0;
      o_frame_done <= 1'b0;
      o_frame_ok   <= 1'b0;
    end else begin
      o_sym_ready  <= (state_nxt == ST_LOAD) && gap_zero_nxt;
      o_sc_resb    <= (state_nxt != ST_CLEAR);
      o_frame_done <= (state_nxt == ST_EVAL);
      if (xfer) begin
        o_sc_data <= i_sym;
        o_sc_sync <= ~o_sc_sync;
      end
      if (state_nxt == ST_EVAL) begin
        o_syn0     <= i_s0;
        o_syn1     <= i_s1;
        o_syn2     <= i_s2;
        o_syn3     <= i_s3;
        o_frame_ok <= syn_ok;
      end
    end
  end

`ifdef RS_DEC_FRAME_CTRL_STATS_EN
  logic [ERR_W-1:0] err_cnt;

  always_ff @(posedge i_clk or negedge i_resb) begin
    if (!i_resb)
      err_cnt <= '0;
    else if ((state_nxt == ST_EVAL) && !syn_ok && (err_cnt != {ERR_W{1'b1}}))
      err_cnt <= err_cnt + ERR_W'(1);
  end

  assign o_err_frames = err_cnt;
`else
  assign o_err_frames = '0;
`endif

endmodule

// File: tb/tb_rs_dec_frame_ctrl.sv
// Self-checking bench for rs_dec_frame_ctrl with a behavioural syndrome calculator.
module tb_rs_dec_frame_ctrl;

  localparam int GAP = 4;
`ifdef RS_DEC_FRAME_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, sync = 1'b0, vld = 1'b0;
  logic [7:0]  sym = '0;
  logic        rdy, sc_sync, sc_resb, done, ok;
  logic [7:0]  sc_data, syn0, syn1, syn2, syn3;
  logic [15:0] errf;
  logic [7:0]  cs [4];
  logic        t1, t2;

  int n_chk = 0, n_fail = 0;
  int exp_err = 0;
  logic [7:0] frm [32];

  int r_lat, r_last, r_nx, r_min, r_max, r_done, r_resb;
  logic [31:0] r_syn;
  logic r_ok;
  logic [15:0] r_err;

  always #5 clk = ~clk;

  rs_dec_frame_ctrl #(.SYM_GAP(GAP), .FRAME_LEN(32)) dut (
    .i_clk(clk), .i_resb(rst_n), .i_frame_sync(sync), .i_sym(sym), .i_sym_valid(vld),
    .o_sym_ready(rdy), .o_sc_data(sc_data), .o_sc_sync(sc_sync), .o_sc_resb(sc_resb),
    .i_s0(cs[0]), .i_s1(cs[1]), .i_s2(cs[2]), .i_s3(cs[3]),
    .o_syn0(syn0), .o_syn1(syn1), .o_syn2(syn2), .o_syn3(syn3),
    .o_frame_done(done), .o_frame_ok(ok), .o_err_frames(errf)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] gpow(input int e);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < (e % 255); i++) r = gmul(r, 8'h02);
    return r;
  endfunction

  // Received polynomial evaluated at alpha^j; frm[0] is the highest-order coefficient.
  function automatic logic [7:0] ref_syn(input int j);
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < 32; i++) s = s ^ gmul(frm[i], gpow(j * (31 - i)));
    return s;
  endfunction

  function automatic logic [31:0] ref_vec();
    return {ref_syn(0), ref_syn(1), ref_syn(2), ref_syn(3)};
  endfunction

  // Calculator stand-in: 2-flop toggle detect, accumulates two edges after a toggle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t1 <= 1'b0; t2 <= 1'b0;
      for (int j = 0; j < 4; j++) cs[j] <= '0;
    end else begin
      t1 <= sc_sync; t2 <= t1;
      if (!sc_resb) begin
        for (int j = 0; j < 4; j++) cs[j] <= '0;
      end else if (t1 ^ t2) begin
        for (int j = 0; j < 4; j++) cs[j] <= gmul(cs[j], gpow(j)) ^ sc_data;
      end
    end
  end

  task automatic bump_err();
    if (STATS && (ref_vec() != 32'h0) && exp_err < 65535) exp_err++;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 32; i++) frm[i] = 8'($urandom);
  endtask

  task automatic fill_zero();
    for (int i = 0; i < 32; i++) frm[i] = '0;
  endtask

  // Drives one frame; abort_after>=0 re-syncs once that many symbols were sent
  // (coincident with a ready cycle) and continues with an all-zero frame.
  task automatic run_frame(input int period, input int abort_after, input bit chain);
    int k, idx, last, base;
    bit aborted;
    if (!chain) @(negedge clk);
    sync = 1'b1; vld = 1'b0;
    k = -1; idx = 0; last = -100; base = 0; aborted = 1'b0;
    r_lat = -1; r_last = -1; r_nx = 0; r_min = 1000; r_max = 0; r_done = 0; r_resb = 0;
    for (int s = 0; s < 2000; s++) begin
      @(posedge clk); k++;
      @(negedge clk);
      if (!sc_resb) r_resb++;
      if (done) begin
        r_done++; r_lat = k - base; r_last = last - base;
        r_syn = {syn0, syn1, syn2, syn3}; r_ok = ok; r_err = errf;
        break;
      end
      sync = 1'b0;
      vld  = ((k % period) == 0);
      sym  = (idx < 32) ? frm[idx] : 8'($urandom);
      if (!aborted && abort_after >= 0 && idx == abort_after && rdy) begin
        sync = 1'b1; aborted = 1'b1; base = k + 1; idx = 0;
        r_nx = 0; r_min = 1000; r_max = 0; last = -100;
        fill_zero();
      end else if (vld && rdy) begin
        if (last >= 0) begin
          if (k + 1 - last < r_min) r_min = k + 1 - last;
          if (k + 1 - last > r_max) r_max = k + 1 - last;
        end
        last = k + 1; idx++; r_nx++;
      end
    end
    vld = 1'b0; sync = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", rdy); end
    n_chk++; if (sc_data !== 8'h00) begin n_fail++; $display("FAIL reset_sc_data: got %h expected 00", sc_data); end
    n_chk++; if (sc_sync !== 1'b0) begin n_fail++; $display("FAIL reset_sc_sync: got %b expected 0", sc_sync); end
    n_chk++; if (sc_resb !== 1'b1) begin n_fail++; $display("FAIL reset_sc_resb: got %b expected 1", sc_resb); end
    n_chk++; if ({syn0, syn1, syn2, syn3} !== 32'h0) begin n_fail++; $display("FAIL reset_syn: got %h expected 0", {syn0, syn1, syn2, syn3}); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_chk++; if (ok !== 1'b0) begin n_fail++; $display("FAIL reset_ok: got %b expected 0", ok); end
    n_chk++; if (errf !== 16'h0) begin n_fail++; $display("FAIL reset_err: got %h expected 0", errf); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL idle_ready: got %b expected 0", rdy); end
  endtask

  task automatic test_zero_frame();
    fill_zero();
    run_frame(1, -1, 1'b0);
    bump_err();
    n_chk++; if (r_done !== 1) begin n_fail++; $display("FAIL zero_done: got %0d expected 1", r_done); end
    n_chk++; if (r_lat !== 2 + 32 * GAP) begin n_fail++; $display("FAIL zero_latency: got %0d expected %0d", r_lat, 2 + 32 * GAP); end
    n_chk++; if (r_nx !== 32) begin n_fail++; $display("FAIL zero_xfers: got %0d expected 32", r_nx); end
    n_chk++; if (r_min !== GAP || r_max !== GAP) begin n_fail++; $display("FAIL zero_spacing: got %0d..%0d expected %0d", r_min, r_max, GAP); end
    n_chk++; if (r_syn !== 32'h0) begin n_fail++; $display("FAIL zero_syn: got %h expected 0", r_syn); end
    n_chk++; if (r_ok !== 1'b1) begin n_fail++; $display("FAIL zero_ok: got %b expected 1", r_ok); end
    n_chk++; if (r_resb !== 1) begin n_fail++; $display("FAIL zero_resb_cycles: got %0d expected 1", r_resb); end
  endtask

  task automatic test_single_one();
    fill_zero(); frm[0] = 8'h01;
    run_frame(1, -1, 1'b0);
    bump_err();
    n_chk++; if (r_syn[31:24] !== 8'h01) begin n_fail++; $display("FAIL one_syn0: got %h expected 01", r_syn[31:24]); end
    n_chk++; if (r_syn !== ref_vec()) begin n_fail++; $display("FAIL one_syn: got %h expected %h", r_syn, ref_vec()); end
    n_chk++; if (r_ok !== 1'b0) begin n_fail++; $display("FAIL one_ok: got %b expected 0", r_ok); end
    n_chk++; if (r_err !== 16'(STATS ? exp_err : 0)) begin n_fail++; $display("FAIL one_err: got %0d expected %0d", r_err, STATS ? exp_err : 0); end
  endtask

  task automatic test_reset_mid();
    int idx, rdy_hi;
    fill_random();
    @(negedge clk); sync = 1'b1; idx = 0;
    for (int s = 0; s < 400 && idx < 5; s++) begin
      @(negedge clk);
      sync = 1'b0; vld = 1'b1; sym = frm[idx];
      if (rdy) idx++;
    end
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0; vld = 1'b0; exp_err = 0;
    #1;
    n_chk++; if (idx !== 5) begin n_fail++; $display("FAIL mid_xfers: got %0d expected 5", idx); end
    n_chk++; if ({rdy, sc_sync, sc_resb, done, ok} !== 5'b00100) begin n_fail++; $display("FAIL mid_ctrl: got %b expected 00100", {rdy, sc_sync, sc_resb, done, ok}); end
    n_chk++; if ({sc_data, syn0, syn1, syn2, syn3, errf} !== 56'h0) begin n_fail++; $display("FAIL mid_data: got %h expected 0", {sc_data, syn0, syn1, syn2, syn3, errf}); end
    @(negedge clk); rst_n = 1'b1; vld = 1'b1; rdy_hi = 0;
    for (int s = 0; s < 20; s++) begin
      @(negedge clk);
      if (rdy || sc_sync) rdy_hi++;
    end
    vld = 1'b0;
    n_chk++; if (rdy_hi !== 0) begin n_fail++; $display("FAIL mid_no_resume: got %0d expected 0", rdy_hi); end
    fill_zero();
    run_frame(1, -1, 1'b0);
    n_chk++; if (r_lat !== 2 + 32 * GAP || r_ok !== 1'b1) begin n_fail++; $display("FAIL mid_next_frame: got lat %0d ok %b expected %0d 1", r_lat, r_ok, 2 + 32 * GAP); end
  endtask

  task automatic test_gapped();
    fill_random();
    run_frame(7, -1, 1'b0);
    n_chk++; if (r_nx !== 32) begin n_fail++; $display("FAIL gap_xfers: got %0d expected 32", r_nx); end
    n_chk++; if (r_min !== 7 || r_max !== 7) begin n_fail++; $display("FAIL gap_spacing: got %0d..%0d expected 7", r_min, r_max); end
    n_chk++; if (r_lat !== r_last + GAP) begin n_fail++; $display("FAIL gap_latency: got %0d expected %0d", r_lat, r_last + GAP); end
    n_chk++; if (r_syn !== ref_vec()) begin n_fail++; $display("FAIL gap_syn: got %h expected %h", r_syn, ref_vec()); end
    n_chk++; if (r_ok !== (ref_vec() == 32'h0)) begin n_fail++; $display("FAIL gap_ok: got %b", r_ok); end
    bump_err();
    n_chk++; if (r_err !== 16'(STATS ? exp_err : 0)) begin n_fail++; $display("FAIL gap_err: got %0d expected %0d", r_err, STATS ? exp_err : 0); end
  endtask

  task automatic test_abort();
    fill_random();
    run_frame(1, 10, 1'b0);
    bump_err();
    n_chk++; if (r_done !== 1 || r_lat !== 2 + 32 * GAP) begin n_fail++; $display("FAIL abort_latency: got %0d/%0d expected 1/%0d", r_done, r_lat, 2 + 32 * GAP); end
    n_chk++; if (r_resb !== 2) begin n_fail++; $display("FAIL abort_resb_cycles: got %0d expected 2", r_resb); end
    n_chk++; if (r_nx !== 32) begin n_fail++; $display("FAIL abort_xfers: got %0d expected 32", r_nx); end
    n_chk++; if (r_syn !== 32'h0 || r_ok !== 1'b1) begin n_fail++; $display("FAIL abort_clean: got %h ok %b expected 0 1", r_syn, r_ok); end
  endtask

  task automatic test_back_to_back();
    fill_random(); frm[5] = 8'hA5;
    run_frame(1, -1, 1'b0);
    bump_err();
    n_chk++; if (r_syn !== ref_vec()) begin n_fail++; $display("FAIL b2b_first_syn: got %h expected %h", r_syn, ref_vec()); end
    fill_zero();
    run_frame(1, -1, 1'b1);
    bump_err();
    n_chk++; if (r_lat !== 2 + 32 * GAP || r_resb !== 1) begin n_fail++; $display("FAIL b2b_second: got lat %0d resb %0d expected %0d 1", r_lat, r_resb, 2 + 32 * GAP); end
    n_chk++; if (r_ok !== 1'b1 || r_syn !== 32'h0) begin n_fail++; $display("FAIL b2b_second_ok: got %b %h expected 1 0", r_ok, r_syn); end
    n_chk++; if (r_err !== 16'(STATS ? exp_err : 0)) begin n_fail++; $display("FAIL b2b_err: got %0d expected %0d", r_err, STATS ? exp_err : 0); end
  endtask

  task automatic test_random();
    int period;
    for (int f = 0; f < 6; f++) begin
      period = $urandom_range(1, 9);
      if ($urandom_range(0, 2) == 0) fill_zero(); else fill_random();
      run_frame(period, -1, 1'b0);
      bump_err();
      n_chk++; if (r_nx !== 32 || r_min < GAP) begin n_fail++; $display("FAIL rnd_xfers[%0d]: got %0d min %0d expected 32 >=%0d", f, r_nx, r_min, GAP); end
      n_chk++; if (r_lat !== r_last + GAP) begin n_fail++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", f, r_lat, r_last + GAP); end
      n_chk++; if (r_syn !== ref_vec()) begin n_fail++; $display("FAIL rnd_syn[%0d]: got %h expected %h", f, r_syn, ref_vec()); end
      n_chk++; if (r_ok !== (ref_vec() == 32'h0)) begin n_fail++; $display("FAIL rnd_ok[%0d]: got %b", f, r_ok); end
      n_chk++; if (r_err !== 16'(STATS ? exp_err : 0)) begin n_fail++; $display("FAIL rnd_err[%0d]: got %0d expected %0d", f, r_err, STATS ? exp_err : 0); end
    end
  endtask

`ifdef RS_DEC_FRAME_CTRL_STATS_EN
  task automatic test_saturate();
    @(negedge clk);
    force dut.err_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.err_cnt;
    exp_err = 16'hFFFE;
    for (int f = 0; f < 2; f++) begin
      fill_random(); frm[0] = 8'h01; frm[1] = 8'h00;
      run_frame(1, -1, 1'b0);
      bump_err();
      n_chk++; if (r_err !== 16'hFFFF) begin n_fail++; $display("FAIL sat_err[%0d]: got %h expected ffff", f, r_err); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_zero_frame();
    test_single_one();
    test_reset_mid();
    test_gapped();
    test_abort();
    test_back_to_back();
    test_random();
`ifdef RS_DEC_FRAME_CTRL_STATS_EN
    test_saturate();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
